// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM arbiter: FSM state encoding and master ids.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_t;

endpackage

// File: rtl/ram_rr_pick.sv
// Combinational round-robin picker for two requesters.
module ram_rr_pick
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  master_id_t rr_last,
  output logic       gnt_valid,
  output master_id_t gnt_id
);

  // Lone requester wins; on contention the master not granted last time wins.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = M0;
    case (req)
      2'b01:   gnt_id = M0;
      2'b10:   gnt_id = M1;
      2'b11:   gnt_id = (rr_last == M0) ? M1 : M0;
      default: gnt_id = M0;
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one ram_memory between instruction fetch (m0) and load/store (m1).
// One RAM access at a time, round-robin on contention, registered responses.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned ADDR_BASE = 0,
  parameter int unsigned MEM_SIZE  = 256
)
(
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [BUS_WIDTH-1:0] m0_addr,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  output logic                 m0_done,
  output logic [BUS_WIDTH-1:0] m0_rdata,
  output logic                 m0_err,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [BUS_WIDTH-1:0] m1_addr,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  output logic                 m1_done,
  output logic [BUS_WIDTH-1:0] m1_rdata,
  output logic                 m1_err,
  output logic                 ram_write_en,
  output logic [BUS_WIDTH-1:0] ram_addr_write,
  output logic [BUS_WIDTH-1:0] ram_data_write,
  output logic [BUS_WIDTH-1:0] ram_addr_read,
  input  logic [BUS_WIDTH-1:0] ram_data_read,
  input  logic                 ram_ready,
  output logic                 busy
);

  localparam logic [BUS_WIDTH-1:0] BASE_W = BUS_WIDTH'(ADDR_BASE);
  localparam logic [BUS_WIDTH-1:0] SIZE_W = BUS_WIDTH'(MEM_SIZE);

  state_t               state;
  state_t               state_nxt;
  master_id_t           rr_last;
  master_id_t           lat_id;
  master_id_t           gnt_id;
  logic                 gnt_valid;
  logic                 grant;
  logic                 lat_we;
  logic [BUS_WIDTH-1:0] lat_addr;
  logic [BUS_WIDTH-1:0] lat_wdata;
  logic [BUS_WIDTH-1:0] offset;
  logic                 in_range;
  logic [BUS_WIDTH-1:0] acc_rdata;
  logic                 acc_err;

  ram_rr_pick u_pick (
    .req       ({m1_req, m0_req}),
    .rr_last   (rr_last),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Addresses below the base wrap to a huge offset, so one compare covers both ends.
  assign offset    = lat_addr - BASE_W;
  assign in_range  = (offset < SIZE_W);
  assign grant     = (state == IDLE) && ram_ready && gnt_valid;
  assign acc_rdata = (in_range && ram_ready && !lat_we) ? ram_data_read : '0;
  assign acc_err   = !in_range || !ram_ready;

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= INIT;
    else         state <= state_nxt;
  end

  // Next-state logic: ACCESS always lasts one cycle, RESP falls back to INIT if the RAM drops ready.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (ram_ready) state_nxt = IDLE;
      IDLE: begin
        if (!ram_ready)     state_nxt = INIT;
        else if (gnt_valid) state_nxt = ACCESS;
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = ram_ready ? IDLE : INIT;
      default: state_nxt = INIT;
    endcase
  end

  // Latch the winning transaction and remember who was granted.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rr_last   <= M1;
      lat_id    <= M0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant) begin
      rr_last <= gnt_id;
      lat_id  <= gnt_id;
      if (gnt_id == M1) begin
        lat_we    <= m1_we;
        lat_addr  <= m1_addr;
        lat_wdata <= m1_wdata;
      end else begin
        lat_we    <= m0_we;
        lat_addr  <= m0_addr;
        lat_wdata <= m0_wdata;
      end
    end
  end

  // Capture the access result into the owning master's response registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m0_rdata <= '0;
      m0_err   <= 1'b0;
      m1_rdata <= '0;
      m1_err   <= 1'b0;
    end else if (state == ACCESS) begin
      if (lat_id == M1) begin
        m1_rdata <= acc_rdata;
        m1_err   <= acc_err;
      end else begin
        m0_rdata <= acc_rdata;
        m0_err   <= acc_err;
      end
    end
  end

  assign ram_addr_read  = lat_addr;
  assign ram_addr_write = lat_addr;
  assign ram_data_write = lat_wdata;
  assign ram_write_en   = (state == ACCESS) && lat_we && in_range && ram_ready;
  assign m0_done        = (state == RESP) && (lat_id == M0);
  assign m1_done        = (state == RESP) && (lat_id == M1);
  assign busy           = (state == ACCESS) || (state == RESP);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed transactions push expected
// responses; monitors pop and compare on every done pulse.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        nreset;
  logic        ram_ready;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m0_err, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_write_en, busy;
  logic [31:0] ram_addr_write, ram_data_write, ram_addr_read, ram_data_read;

  logic        b_m0_req, b_m0_we;
  logic [31:0] b_m0_addr, b_m0_wdata;
  logic        b_m0_done, b_m0_err, b_m1_done, b_m1_err;
  logic [31:0] b_m0_rdata, b_m1_rdata;
  logic        b_write_en, b_busy;
  logic [31:0] b_addr_w, b_data_w, b_addr_r;

  always #5 clk = ~clk;

  ram_arbiter #(.BUS_WIDTH(32), .ADDR_BASE(0), .MEM_SIZE(256)) u_dut (
    .clk(clk), .nreset(nreset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_write_en(ram_write_en), .ram_addr_write(ram_addr_write),
    .ram_data_write(ram_data_write), .ram_addr_read(ram_addr_read),
    .ram_data_read(ram_data_read), .ram_ready(ram_ready), .busy(busy)
  );

  // Second instance with a non-zero base window; its RAM returns a fixed word.
  ram_arbiter #(.BUS_WIDTH(32), .ADDR_BASE(32'h40), .MEM_SIZE(256)) u_dut_b (
    .clk(clk), .nreset(nreset),
    .m0_req(b_m0_req), .m0_we(b_m0_we), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
    .m0_done(b_m0_done), .m0_rdata(b_m0_rdata), .m0_err(b_m0_err),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_wdata(32'h0),
    .m1_done(b_m1_done), .m1_rdata(b_m1_rdata), .m1_err(b_m1_err),
    .ram_write_en(b_write_en), .ram_addr_write(b_addr_w),
    .ram_data_write(b_data_w), .ram_addr_read(b_addr_r),
    .ram_data_read(32'h1234_5678), .ram_ready(ram_ready), .busy(b_busy)
  );

  // RAM model: unwritten word i reads as 0x1000_0000 + i.
  logic [31:0]  mem [256];
  logic [255:0] wrote = '0;

  always_comb begin
    ram_data_read = '0;
    if (ram_addr_read < 32'd256)
      ram_data_read = wrote[ram_addr_read[7:0]] ? mem[ram_addr_read[7:0]]
                                                : (32'h1000_0000 + ram_addr_read);
  end

  always @(posedge clk) begin
    if (ram_write_en && ram_addr_write < 32'd256) begin
      mem[ram_addr_write[7:0]]   <= ram_data_write;
      wrote[ram_addr_write[7:0]] <= 1'b1;
    end
  end

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          gap;
  } exp_t;

  exp_t sb[$];
  exp_t sb_b[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_done = 0;
  int   wr_cnt = 0;
  int   b_wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_write_en) wr_cnt <= wr_cnt + 1;
    if (b_write_en)   b_wr_cnt <= b_wr_cnt + 1;
  end

  // Monitor for the main instance.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (m0_done && m1_done) begin
      chk("done_both", 32'd1, 32'd0);
    end else if (m0_done || m1_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, m1_done}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("done_id", {31'b0, m1_done}, e.id);
        chk("rdata", m1_done ? m1_rdata : m0_rdata, e.rdata);
        chk("err", {31'b0, m1_done ? m1_err : m0_err}, {31'b0, e.err});
        if (e.gap != 0) chk("done_gap", cyc - last_done, e.gap);
      end
      last_done = cyc;
    end
  end

  // Monitor for the offset-window instance.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_m1_done) begin
      chk("b_m1_done", 32'd1, 32'd0);
    end else if (b_m0_done) begin
      if (sb_b.size() == 0) begin
        chk("b_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_b.pop_front();
        chk("b_rdata", b_m0_rdata, e.rdata);
        chk("b_err", {31'b0, b_m0_err}, {31'b0, e.err});
      end
    end
  end

  // m: 0 = m0, 1 = m1, 2 = m0 of the offset-window instance.
  task automatic txn(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input logic exp_err);
    exp_t e;
    int   dcyc;
    e.id = (m == 1) ? 1 : 0;
    e.rdata = exp_rd;
    e.err = exp_err;
    e.gap = 0;
    if (m == 2) sb_b.push_back(e);
    else        sb.push_back(e);
    case (m)
      0: begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
      1: begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
      default: begin b_m0_req = 1'b1; b_m0_we = we; b_m0_addr = addr; b_m0_wdata = wdata; end
    endcase
    dcyc = -1;
    for (int i = 0; i < 40 && dcyc < 0; i++) begin
      @(negedge clk);
      if ((m == 0 && m0_done) || (m == 1 && m1_done) || (m == 2 && b_m0_done)) dcyc = cyc;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    b_m0_req = 1'b0;
    if (dcyc < 0) begin
      total++;
      bad++;
      $display("FAIL txn_timeout master=%0d actual=no_done required=done", m);
    end
  endtask

  // Both masters hold read requests for n completions (m0 reads 0x01, m1 reads 0x02).
  task automatic both_run(input int n);
    exp_t e;
    int   cnt;
    for (int k = 0; k < n; k++) begin
      e.id = k % 2;
      e.rdata = (k % 2 == 1) ? 32'h1000_0002 : 32'h1000_0001;
      e.err = 1'b0;
      e.gap = (k == 0) ? 0 : 3;
      sb.push_back(e);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h01;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h02;
    cnt = 0;
    for (int i = 0; i < 6 * n + 20 && cnt < n; i++) begin
      @(negedge clk);
      if (m0_done || m1_done) cnt++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("both_run_count", cnt, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dcyc;
    int rise;
    int w0;
    nreset = 1'b0; ram_ready = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {30'b0, m1_done, m0_done}, 32'd0);
    chk("rst_err", {30'b0, m1_err, m0_err}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_ram_addr", ram_addr_read | ram_addr_write, 32'd0);
    chk("rst_write_en", {31'b0, ram_write_en}, 32'd0);
    nreset = 1'b1;

    // RAM not ready for 5 cycles while m0 holds a read of 0x10.
    sb.push_back('{id: 0, rdata: 32'h1000_0010, err: 1'b0, gap: 0});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_done_not_ready", {31'b0, m0_done | busy}, 32'd0);
    end
    ram_ready = 1'b1;
    rise = cyc;
    dcyc = -1;
    for (int i = 0; i < 20 && dcyc < 0; i++) begin
      @(negedge clk);
      if (m0_done) dcyc = cyc;
    end
    m0_req = 1'b0;
    chk("ready_to_done", dcyc - rise, 32'd3);

    // m1 write, then m0 reads it back.
    w0 = wr_cnt;
    txn(1, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0);
    chk("write_pulse", wr_cnt - w0, 32'd1);
    chk("mem_20", mem[8'h20], 32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h20, 32'h0, 32'hDEAD_BEEF, 1'b0);
    txn(1, 1'b0, 32'h30, 32'h0, 32'h1000_0030, 1'b0);

    // Contention: alternation starting with m0, one completion every 3 cycles.
    both_run(6);

    // Out-of-range write at exactly the top boundary, then the last valid word.
    w0 = wr_cnt;
    txn(0, 1'b1, 32'h100, 32'hCAFE_F00D, 32'h0, 1'b1);
    chk("oob_no_write", wr_cnt - w0, 32'd0);
    txn(0, 1'b1, 32'hFF, 32'h0BAD_F00D, 32'h0, 1'b0);
    txn(0, 1'b0, 32'hFF, 32'h0, 32'h0BAD_F00D, 1'b0);

    // Offset window: one below the base is out of range, the base itself is valid.
    w0 = b_wr_cnt;
    txn(2, 1'b1, 32'h3F, 32'h55AA_55AA, 32'h0, 1'b1);
    chk("below_base_no_write", b_wr_cnt - w0, 32'd0);
    txn(2, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 1'b0);

    // Reset during ACCESS of an m1 write.
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h50; m1_wdata = 32'hFFFF_0000;
    @(negedge clk);
    chk("access_write_en", {31'b0, ram_write_en}, 32'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_busy_we", {30'b0, busy, ram_write_en}, 32'd0);
    chk("mid_rst_done", {30'b0, m1_done, m0_done}, 32'd0);
    chk("mid_rst_rdata", m0_rdata | m1_rdata, 32'd0);
    chk("mid_rst_ram_bus", ram_addr_write | ram_data_write, 32'd0);
    m1_req = 1'b0; m1_we = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_write", {31'b0, wrote[8'h50]}, 32'd0);
    nreset = 1'b1;
    both_run(2);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size() + sb_b.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
